// File: rtl/polar_ring_pkg.sv
// Shared types and helpers for the polar ring sequencer.
// Holds default sizes, FSM state encodings and circular-pointer arithmetic.
package polar_ring_pkg;

    localparam int AW_DEF      = 10;
    localparam int MAX_OUT_DEF = 4;

    typedef enum logic [1:0] {
        I_IDLE  = 2'd0,
        I_RDX   = 2'd1,
        I_RDY   = 2'd2,
        I_OFFER = 2'd3
    } in_state_t;

    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_WR_R = 2'd1,
        O_WR_T = 2'd2
    } out_state_t;

    // Words between consumer and producer, modulo 2^aw.
    function automatic logic [15:0] ring_used(
        input logic [15:0] head,
        input logic [15:0] tail,
        input int          aw
    );
        logic [15:0] mask;
        mask = 16'((32'd1 << aw) - 32'd1);
        return (head - tail) & mask;
    endfunction

    // Writable words; one slot stays empty so full != empty.
    function automatic logic [15:0] ring_free(
        input logic [15:0] head,
        input logic [15:0] tail,
        input int          aw
    );
        logic [15:0] mask;
        mask = 16'((32'd1 << aw) - 32'd1);
        return (tail - head - 16'd1) & mask;
    endfunction

endpackage

// File: rtl/polar_ring_writer.sv
// Output FSM: captures one (r,theta) result and writes it to obuf as two words.
// Ports: Clk/Rst, Pending (results owed), Rsp* handshake, obuf port B, ObufHead, PairCount, Done, Active.
module polar_ring_writer
    import polar_ring_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Pending,
    input  logic          RspValid,
    output logic          RspReady,
    input  logic [31:0]   RspR,
    input  logic [31:0]   RspTheta,
    output logic          ObufWe,
    output logic [AW-1:0] ObufAddr,
    output logic [31:0]   ObufData,
    output logic [AW-1:0] ObufHead,
    output logic [15:0]   PairCount,
    output logic          Done,
    output logic          Active
);

    out_state_t    st_q, st_d;
    logic [31:0]   r_q, t_q;
    logic [AW-1:0] head_q;
    logic [15:0]   cnt_q;
    logic          take;

    assign take      = (st_q == O_IDLE) && RspValid && Pending;
    assign ObufAddr  = head_q;
    assign ObufHead  = head_q;
    assign PairCount = cnt_q;
    assign Active    = (st_q != O_IDLE);

    always_comb begin
        st_d     = st_q;
        RspReady = 1'b0;
        ObufWe   = 1'b0;
        ObufData = 32'd0;
        Done     = 1'b0;
        unique case (st_q)
            O_IDLE: begin
                RspReady = Pending;
                if (take) st_d = O_WR_R;
            end
            O_WR_R: begin
                ObufWe   = 1'b1;
                ObufData = r_q;
                st_d     = O_WR_T;
            end
            O_WR_T: begin
                ObufWe   = 1'b1;
                ObufData = t_q;
                Done     = 1'b1;
                st_d     = O_IDLE;
            end
            default: st_d = O_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            st_q   <= O_IDLE;
            r_q    <= 32'd0;
            t_q    <= 32'd0;
            head_q <= '0;
            cnt_q  <= 16'd0;
        end else begin
            st_q <= st_d;
            if (take) begin
                r_q <= RspR;
                t_q <= RspTheta;
            end
            if (ObufWe) head_q <= head_q + 1'b1;
            if (Done)   cnt_q  <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/polar_ring_sequencer.sv
// Moves (x,y) pairs from ibuf to the accelerator and (r,theta) results to obuf.
// Ports: Clk/Rst/SftRst, ibuf read port + pointers, obuf write port + pointers, Req/Rsp handshakes, Busy, PairCount.
module polar_ring_sequencer
    import polar_ring_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int MAX_OUT = MAX_OUT_DEF
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          SftRst,
    input  logic [AW-1:0] IbufHead,
    output logic [AW-1:0] IbufTail,
    output logic [AW-1:0] IbufAddr,
    input  logic [31:0]   IbufData,
    input  logic [AW-1:0] ObufTail,
    output logic [AW-1:0] ObufHead,
    output logic          ObufWe,
    output logic [AW-1:0] ObufAddr,
    output logic [31:0]   ObufData,
    output logic          ReqValid,
    input  logic          ReqReady,
    output logic [31:0]   ReqX,
    output logic [31:0]   ReqY,
    input  logic          RspValid,
    output logic          RspReady,
    input  logic [31:0]   RspR,
    input  logic [31:0]   RspTheta,
    output logic          Busy,
    output logic [15:0]   PairCount
);

    logic          rst;
    in_state_t     in_q, in_d;
    logic [AW-1:0] tail_q;
    logic [3:0]    out_q;
    logic [15:0]   avail, free;
    logic [4:0]    need;
    logic          go, inc, dec, wr_active;

    assign rst = Rst | SftRst;

    assign avail = ring_used(16'(IbufHead), 16'(tail_q), AW);
    assign free  = ring_free(16'(ObufHead), 16'(ObufTail), AW);
    // Reserve room for every result in flight plus the pair about to issue.
    assign need  = {out_q, 1'b0} + 5'd2;
    assign go    = (avail >= 16'd2)
                && (out_q < 4'(MAX_OUT))
                && (free >= {11'd0, need});

    assign IbufTail = tail_q;
    assign IbufAddr = tail_q;
    assign ReqValid = (in_q == I_OFFER);
    assign inc      = (in_q == I_OFFER) && ReqReady;
    assign Busy     = (in_q != I_IDLE) || wr_active || (out_q != 4'd0);

    always_comb begin
        in_d = in_q;
        unique case (in_q)
            I_IDLE:  if (go) in_d = I_RDX;
            I_RDX:   in_d = I_RDY;
            I_RDY:   in_d = I_OFFER;
            I_OFFER: if (ReqReady) in_d = I_IDLE;
            default: in_d = I_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            in_q   <= I_IDLE;
            tail_q <= '0;
            ReqX   <= 32'd0;
            ReqY   <= 32'd0;
            out_q  <= 4'd0;
        end else begin
            in_q <= in_d;
            // Tail steps past x on IDLE exit and past y in RDX.
            if ((in_q == I_IDLE && go) || in_q == I_RDX)
                tail_q <= tail_q + 1'b1;
            if (in_q == I_RDX) ReqX <= IbufData;
            if (in_q == I_RDY) ReqY <= IbufData;
            unique case ({inc, dec})
                2'b10:   out_q <= out_q + 4'd1;
                2'b01:   out_q <= out_q - 4'd1;
                default: out_q <= out_q;
            endcase
        end
    end

    polar_ring_writer #(.AW(AW)) u_writer (
        .Clk       (Clk),
        .Rst       (rst),
        .Pending   (out_q != 4'd0),
        .RspValid  (RspValid),
        .RspReady  (RspReady),
        .RspR      (RspR),
        .RspTheta  (RspTheta),
        .ObufWe    (ObufWe),
        .ObufAddr  (ObufAddr),
        .ObufData  (ObufData),
        .ObufHead  (ObufHead),
        .PairCount (PairCount),
        .Done      (dec),
        .Active    (wr_active)
    );

endmodule
